sfx_sequencer: RTL and testbench

Sound-effect sequencer that sits directly upstream of `note_gen` in the audio path. It turns single-cycle game events into short multi-note melodies: jump, landing, countdown and game-over. For each event it drives a registered note divisor and volume straight into `note_gen`'s left and right divisor inputs and its volume input. Because divisors are stored as precomputed constants, no runtime divider is needed on the audio path.

---
 rtl/sfx_sequencer_if.sv | 29 ++
 rtl/sfx_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_sfx_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sfx_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : sfx_sequencer_if
// Brief    : Game-event inputs and note_gen-facing outputs of sfx_sequencer.
// Revision : 1.0
// ============================================================================
interface sfx_sequencer_if;
   logic        jump_evt;
   logic        land_evt;
   logic        cd_evt;
   logic [2:0]  cd_code;
   logic        over_evt;
   logic        mute;
   logic [21:0] note_div;
   logic [2:0]  volume;
   logic        busy;
   logic [2:0]  cur_sfx;

   modport master (
      output jump_evt, land_evt, cd_evt, cd_code, over_evt, mute,
      input  note_div, volume, busy, cur_sfx
   );

   modport slave (
      input  jump_evt, land_evt, cd_evt, cd_code, over_evt, mute,
      output note_div, volume, busy, cur_sfx
   );
endinterface
`default_nettype wire

// File: rtl/sfx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sfx_sequencer
// Brief    : Turns one-cycle game events into short prioritised melodies.
// Revision : 1.0
// ============================================================================
module sfx_sequencer #(
   parameter int         CLK_HZ      = 100_000_000,
   parameter int         STEP_CYCLES = 5_000_000,
   parameter int         GAP_CYCLES  = 100_000,
   parameter logic [2:0] VOLUME      = 3'd5
) (
   input  logic          clk,
   input  logic          rst,
   sfx_sequencer_if.slave bus
);

   localparam int MAX_CNT = (15 * STEP_CYCLES > GAP_CYCLES) ? 15 * STEP_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   localparam logic [21:0] c_div_c4 = 22'(CLK_HZ / (2 * 262));
   localparam logic [21:0] c_div_d4 = 22'(CLK_HZ / (2 * 294));
   localparam logic [21:0] c_div_e4 = 22'(CLK_HZ / (2 * 330));
   localparam logic [21:0] c_div_g4 = 22'(CLK_HZ / (2 * 392));
   localparam logic [21:0] c_div_a4 = 22'(CLK_HZ / (2 * 440));
   localparam logic [21:0] c_div_c5 = 22'(CLK_HZ / (2 * 523));
   localparam logic [21:0] c_div_e5 = 22'(CLK_HZ / (2 * 659));
   localparam logic [21:0] c_div_silent = 22'd1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   // Returns {divisor, ticks}; ticks of 0 terminates the melody.
   function automatic logic [25:0] rom_entry(input logic [2:0] sfx,
                                             input logic [1:0] code,
                                             input logic [1:0] idx);
      logic [25:0] e;
      e = {c_div_silent, 4'd0};
      case (sfx)
         3'd1: begin
            if (idx == 2'd0)      e = {c_div_c5, 4'd2};
            else if (idx == 2'd1) e = {c_div_e5, 4'd2};
         end
         3'd2: begin
            if (idx == 2'd0) e = {c_div_a4, 4'd2};
         end
         3'd3: begin
            if (idx == 2'd0) begin
               case (code)
                  2'd3:    e = {c_div_c4, 4'd3};
                  2'd2:    e = {c_div_d4, 4'd3};
                  2'd1:    e = {c_div_e4, 4'd3};
                  default: e = {c_div_g4, 4'd6};
               endcase
            end
         end
         3'd4: begin
            if (idx == 2'd0)      e = {c_div_e4, 4'd4};
            else if (idx == 2'd1) e = {c_div_d4, 4'd4};
            else if (idx == 2'd2) e = {c_div_c4, 4'd8};
         end
         default: e = {c_div_silent, 4'd0};
      endcase
      return e;
   endfunction

   state_t            r_state, w_state_nxt;
   logic [2:0]        r_sfx, w_sfx_nxt;
   logic [1:0]        r_code, w_code_nxt;
   logic [1:0]        r_idx, w_idx_nxt;
   logic [3:0]        r_ticks, w_ticks_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [21:0]       r_note_div, w_div_nxt;
   logic [2:0]        r_volume, w_vol_nxt;
   logic              r_busy;

   logic              w_cd_ok;
   logic [2:0]        w_evt_pri;
   logic              w_accept;
   logic [25:0]       w_first;
   logic [25:0]       w_next;
   logic              w_has_next;
   logic [CNT_W-1:0]  w_note_len;

   assign w_cd_ok    = bus.cd_evt && !bus.cd_code[2];
   assign w_accept   = (w_evt_pri != 3'd0) && (w_evt_pri >= r_sfx);
   assign w_first    = rom_entry(w_evt_pri, bus.cd_code[1:0], 2'd0);
   assign w_next     = rom_entry(r_sfx, r_code, r_idx + 2'd1);
   assign w_has_next = (r_idx != 2'd3) && (w_next[3:0] != 4'd0);
   assign w_note_len = CNT_W'(r_ticks) * CNT_W'(STEP_CYCLES);

   always_comb begin
      w_evt_pri = 3'd0;
      if (bus.over_evt)      w_evt_pri = 3'd4;
      else if (w_cd_ok)      w_evt_pri = 3'd3;
      else if (bus.land_evt) w_evt_pri = 3'd2;
      else if (bus.jump_evt) w_evt_pri = 3'd1;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sfx_nxt   = r_sfx;
      w_code_nxt  = r_code;
      w_idx_nxt   = r_idx;
      w_ticks_nxt = r_ticks;
      w_cnt_nxt   = r_cnt + CNT_W'(1);
      w_div_nxt   = r_note_div;
      // A newly accepted event overrides whatever the current state would do.
      if (w_accept) begin
         w_state_nxt = S_PLAY;
         w_sfx_nxt   = w_evt_pri;
         w_code_nxt  = bus.cd_code[1:0];
         w_idx_nxt   = 2'd0;
         w_ticks_nxt = w_first[3:0];
         w_cnt_nxt   = '0;
         w_div_nxt   = w_first[25:4];
      end else begin
         case (r_state)
            S_IDLE: begin
               w_cnt_nxt = '0;
            end
            S_PLAY: begin
               if (r_cnt == w_note_len - CNT_W'(1)) begin
                  w_cnt_nxt = '0;
                  w_div_nxt = c_div_silent;
                  if (w_has_next) begin
                     w_state_nxt = S_GAP;
                  end else begin
                     w_state_nxt = S_IDLE;
                     w_sfx_nxt   = 3'd0;
                     w_idx_nxt   = 2'd0;
                     w_ticks_nxt = 4'd0;
                  end
               end
            end
            S_GAP: begin
               if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                  w_state_nxt = S_PLAY;
                  w_idx_nxt   = r_idx + 2'd1;
                  w_ticks_nxt = w_next[3:0];
                  w_cnt_nxt   = '0;
                  w_div_nxt   = w_next[25:4];
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_sfx_nxt   = 3'd0;
               w_cnt_nxt   = '0;
               w_div_nxt   = c_div_silent;
            end
         endcase
      end
      w_vol_nxt = (w_state_nxt == S_PLAY && !bus.mute) ? VOLUME : 3'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_sfx      <= 3'd0;
         r_code     <= 2'd0;
         r_idx      <= 2'd0;
         r_ticks    <= 4'd0;
         r_cnt      <= '0;
         r_note_div <= c_div_silent;
         r_volume   <= 3'd0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_sfx      <= w_sfx_nxt;
         r_code     <= w_code_nxt;
         r_idx      <= w_idx_nxt;
         r_ticks    <= w_ticks_nxt;
         r_cnt      <= w_cnt_nxt;
         r_note_div <= w_div_nxt;
         r_volume   <= w_vol_nxt;
         r_busy     <= (w_state_nxt != S_IDLE);
      end
   end

   assign bus.note_div = r_note_div;
   assign bus.volume   = r_volume;
   assign bus.busy     = r_busy;
   assign bus.cur_sfx  = r_sfx;

endmodule
`default_nettype wire

// File: tb/tb_sfx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sfx_sequencer
// Brief    : Directed self-checking bench for sfx_sequencer (STEP=10, GAP=2).
// Revision : 1.0
// ============================================================================
module tb_sfx_sequencer;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   sfx_sequencer_if bus ();

   sfx_sequencer #(
      .CLK_HZ      (100_000_000),
      .STEP_CYCLES (10),
      .GAP_CYCLES  (2),
      .VOLUME      (3'd5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int div, input int vol,
                          input int bsy, input int sfx);
      chk({tag, ".note_div"}, 32'(bus.note_div), 32'(div));
      chk({tag, ".volume"},   32'(bus.volume),   32'(vol));
      chk({tag, ".busy"},     32'(bus.busy),     32'(bsy));
      chk({tag, ".cur_sfx"},  32'(bus.cur_sfx),  32'(sfx));
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Event lines are raised for one edge; on return the bench sits in cycle 1.
   task automatic pulse(input logic j, input logic l, input logic c,
                        input logic [2:0] code, input logic o);
      bus.jump_evt = j;
      bus.land_evt = l;
      bus.cd_evt   = c;
      bus.cd_code  = code;
      bus.over_evt = o;
      @(negedge clk);
      bus.jump_evt = 1'b0;
      bus.land_evt = 1'b0;
      bus.cd_evt   = 1'b0;
      bus.cd_code  = 3'd0;
      bus.over_evt = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      bus.jump_evt = 1'b0;
      bus.land_evt = 1'b0;
      bus.cd_evt   = 1'b0;
      bus.cd_code  = 3'd0;
      bus.over_evt = 1'b0;
      bus.mute     = 1'b0;
      rst          = 1'b1;

      // Reset
      cyc(2);
      chk_out("reset", 1, 0, 0, 0);
      rst = 1'b0;
      cyc(2);
      chk_out("idle", 1, 0, 0, 0);

      // Jump: C5 x20, gap 2, E5 x20
      pulse(1, 0, 0, 3'd0, 0);
      chk_out("jump.c1", 95602, 5, 1, 1);
      cyc(19);
      chk_out("jump.c20", 95602, 5, 1, 1);
      cyc(1);
      chk_out("jump.c21", 1, 0, 1, 1);
      cyc(1);
      chk_out("jump.c22", 1, 0, 1, 1);
      cyc(1);
      chk_out("jump.c23", 75872, 5, 1, 1);
      cyc(19);
      chk_out("jump.c42", 75872, 5, 1, 1);
      cyc(1);
      chk_out("jump.c43", 1, 0, 0, 0);

      // Countdown code 2: D4 for 30 cycles
      cyc(3);
      pulse(0, 0, 1, 3'd2, 0);
      chk_out("cd2.c1", 170068, 5, 1, 3);
      cyc(29);
      chk_out("cd2.c30", 170068, 5, 1, 3);
      cyc(1);
      chk_out("cd2.c31", 1, 0, 0, 0);

      // Countdown code 0: G4 for 60 cycles
      pulse(0, 0, 1, 3'd0, 0);
      chk_out("cd0.c1", 127551, 5, 1, 3);
      cyc(59);
      chk_out("cd0.c60", 127551, 5, 1, 3);
      cyc(1);
      chk_out("cd0.c61", 1, 0, 0, 0);

      // Countdown code 5 is ignored
      pulse(0, 0, 1, 3'd5, 0);
      chk_out("cd5.c1", 1, 0, 0, 0);
      cyc(3);
      chk_out("cd5.c4", 1, 0, 0, 0);

      // Preemption: land five cycles into jump, later jump dropped
      pulse(1, 0, 0, 3'd0, 0);
      cyc(4);
      chk_out("pre.jump", 95602, 5, 1, 1);
      pulse(0, 1, 0, 3'd0, 0);
      chk_out("pre.l1", 113636, 5, 1, 2);
      cyc(4);
      pulse(1, 0, 0, 3'd0, 0);
      chk_out("pre.l6", 113636, 5, 1, 2);
      cyc(14);
      chk_out("pre.l20", 113636, 5, 1, 2);
      cyc(1);
      chk_out("pre.l21", 1, 0, 0, 0);
      cyc(5);
      chk_out("pre.l26", 1, 0, 0, 0);

      // Equal priority restarts from note 0
      pulse(1, 0, 0, 3'd0, 0);
      cyc(10);
      pulse(1, 0, 0, 3'd0, 0);
      chk_out("rst_eq.c1", 95602, 5, 1, 1);
      cyc(19);
      chk_out("rst_eq.c20", 95602, 5, 1, 1);
      cyc(1);
      chk_out("rst_eq.c21", 1, 0, 1, 1);
      cyc(30);

      // Simultaneous jump+land+over: over wins
      pulse(1, 1, 0, 3'd0, 1);
      chk_out("over.c1", 151515, 5, 1, 4);
      cyc(39);
      chk_out("over.c40", 151515, 5, 1, 4);
      cyc(1);
      chk_out("over.c41", 1, 0, 1, 4);
      cyc(2);
      chk_out("over.c43", 170068, 5, 1, 4);
      cyc(39);
      chk_out("over.c82", 170068, 5, 1, 4);
      cyc(2);
      chk_out("over.c84", 1, 0, 1, 4);
      cyc(1);
      chk_out("over.c85", 190839, 5, 1, 4);
      cyc(79);
      chk_out("over.c164", 190839, 5, 1, 4);
      cyc(1);
      chk_out("over.c165", 1, 0, 0, 0);

      // Over blocks lower priority countdown
      pulse(0, 0, 0, 3'd0, 1);
      cyc(2);
      pulse(0, 0, 1, 3'd3, 0);
      chk_out("over.blk", 151515, 5, 1, 4);
      cyc(3);
      pulse(0, 0, 0, 3'd0, 1);
      chk_out("over.re", 151515, 5, 1, 4);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      chk_out("over.rst", 1, 0, 0, 0);

      // Mute mid-note, then reset mid-note
      pulse(1, 0, 0, 3'd0, 0);
      cyc(2);
      bus.mute = 1'b1;
      cyc(1);
      chk_out("mute.on", 95602, 0, 1, 1);
      bus.mute = 1'b0;
      cyc(1);
      chk_out("mute.off", 95602, 5, 1, 1);
      rst = 1'b1;
      cyc(1);
      chk_out("mid.rst", 1, 0, 0, 0);
      rst = 1'b0;
      cyc(25);
      chk_out("mid.rst.after", 1, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
